// File: rtl/chunked_word_adder.sv
// Multi-cycle WIDTH-bit adder: CHUNK bits per cycle, LSB slice first, registered inter-slice carry.
// Optional signed-overflow output is enabled by defining CHUNK_ADDER_SIGNED_OVF_EN.
module chunked_word_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef CHUNK_ADDER_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("chunked_word_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  sum_r;
    logic              carry;
    logic [IDXW-1:0]   idx;

    logic [CHUNK-1:0]  slice_a;
    logic [CHUNK-1:0]  slice_b;
    logic [CHUNK-1:0]  slice_s;
    logic              slice_cy;
    logic [WIDTH-1:0]  sum_next;

    assign in_ready = (state == IDLE);

    // NOTE: every variable gets a value at the top of always_comb so no path can infer a latch.
    always_comb begin
        slice_a  = a_r[int'(idx)*CHUNK +: CHUNK];
        slice_b  = b_r[int'(idx)*CHUNK +: CHUNK];
        {slice_cy, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry};
        sum_next = sum_r;
        sum_next[int'(idx)*CHUNK +: CHUNK] = slice_s;
    end

`ifdef CHUNK_ADDER_SIGNED_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    logic ovf_next;
    assign ovf_next = slice_cy ^ (slice_a[CHUNK-1] ^ slice_b[CHUNK-1] ^ slice_s[CHUNK-1]);
`endif

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            sum_r     <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
`ifdef CHUNK_ADDER_SIGNED_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= c_in;
                        idx   <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    sum_r <= sum_next;
                    carry <= slice_cy;
                    if (idx == LAST_IDX) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        sum       <= sum_next;
                        c_out     <= slice_cy;
`ifdef CHUNK_ADDER_SIGNED_OVF_EN
                        ovf       <= ovf_next;
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        sum       <= '0;
                        c_out     <= 1'b0;
`ifdef CHUNK_ADDER_SIGNED_OVF_EN
                        ovf       <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_word_adder.sv
// Scoreboard bench for chunked_word_adder (CHUNK=8) plus a directed CHUNK=32 instance.
module tb_chunked_word_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        c_out;
    logic        ovf;

    logic        d1_in_valid;
    logic        d1_in_ready;
    logic [31:0] d1_a;
    logic [31:0] d1_b;
    logic        d1_c_in;
    logic        d1_out_valid;
    logic        d1_out_ready;
    logic [31:0] d1_sum;
    logic        d1_c_out;
    logic        d1_ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    chunked_word_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out)
`ifdef CHUNK_ADDER_SIGNED_OVF_EN
        , .ovf(ovf)
`endif
    );

    chunked_word_adder #(.WIDTH(32), .CHUNK(32)) dut1 (
        .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .a(d1_a), .b(d1_b), .c_in(d1_c_in), .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .sum(d1_sum), .c_out(d1_c_out)
`ifdef CHUNK_ADDER_SIGNED_OVF_EN
        , .ovf(d1_ovf)
`endif
    );

`ifndef CHUNK_ADDER_SIGNED_OVF_EN
    assign ovf    = 1'b0;
    assign d1_ovf = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compares every output transfer against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(sum), 64'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum", 64'(sum), 64'(e.s));
                check("c_out", 64'(c_out), 64'(e.co));
`ifdef CHUNK_ADDER_SIGNED_OVF_EN
                check("ovf", 64'(ovf), 64'(e.ov));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, queue its expected result and check the 4-cycle latency.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tci,
                        input logic [31:0] es, input logic eco, input logic eov);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        a = ta;
        b = tb;
        c_in = tci;
        in_valid = 1'b1;
        sb.push_back('{es, eco, eov});
        step();
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        c_in = 1'b1;
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        check("latency", 64'(n), 64'd4);
    endtask

    task automatic drain();
        step();
        check("out_valid_after_xfer", 64'(out_valid), 64'd0);
        check("sum_zero_after_xfer", 64'(sum), 64'd0);
        check("in_ready_after_xfer", 64'(in_ready), 64'd1);
    endtask

    task automatic d1_send(input logic [31:0] ta, input logic [31:0] tb, input logic tci,
                           input logic [31:0] es, input logic eco, input logic eov);
        int n;
        check("d1_in_ready", 64'(d1_in_ready), 64'd1);
        d1_a = ta;
        d1_b = tb;
        d1_c_in = tci;
        d1_in_valid = 1'b1;
        step();
        d1_in_valid = 1'b0;
        n = 0;
        while (!d1_out_valid && n < 20) begin
            step();
            n++;
        end
        check("d1_latency", 64'(n), 64'd1);
        check("d1_sum", 64'(d1_sum), 64'(es));
        check("d1_c_out", 64'(d1_c_out), 64'(eco));
`ifdef CHUNK_ADDER_SIGNED_OVF_EN
        check("d1_ovf", 64'(d1_ovf), 64'(eov));
`endif
        step();
        check("d1_out_valid_after", 64'(d1_out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        c_in = 1'b0;
        out_ready = 1'b1;
        d1_in_valid = 1'b0;
        d1_a = '0;
        d1_b = '0;
        d1_c_in = 1'b0;
        d1_out_ready = 1'b1;

        // Reset held 3 cycles with operand offers that must be ignored.
        in_valid = 1'b1;
        a = 32'h1;
        b = 32'h1;
        repeat (3) step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_c_out", 64'(c_out), 64'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        step();
        check("in_ready_after_rst", 64'(in_ready), 64'd1);
        check("no_output_after_rst", 64'(out_valid), 64'd0);

        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
        drain();
        send(32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0);
        drain();
        send(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
        drain();

        // Backpressure with ignored operand offers.
        out_ready = 1'b0;
        send(32'h0F0F0F0F, 32'h01010101, 1'b0, 32'h10101010, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 32'hDEADBEEF;
            b = 32'hCAFEF00D;
            step();
            check("bp_sum_hold", 64'(sum), 64'h10101010);
            check("bp_c_out_hold", 64'(c_out), 64'd0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        send(32'h00000001, 32'hFFFFFFFF, 1'b1, 32'h00000001, 1'b1, 1'b0);
        drain();

        // Reset asserted mid-cycle in the second ADD cycle.
        a = 32'h55555555;
        b = 32'h55555555;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        step();
        rst = 1'b0;
        repeat (6) begin
            step();
            check("abort_no_output", 64'(out_valid), 64'd0);
        end
        send(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
        drain();
        send(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
        drain();

        // Degenerate single-slice instance.
        d1_send(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
        d1_send(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
        d1_send(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
        d1_send(32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0);

        step();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
